// File: rtl/mem_test_sequencer_if.sv
// Purpose: command, result and CSR Avalon-MM signals of the memory-test sequencer.
// Ports: none; the sequencer uses the master modport and the mailbox/CSR side uses the slave modport.
// Command: cmd_valid/cmd_ready/cmd_param/abort. Result: res_* plus busy. CSR: csr_* Avalon-MM (no waitrequest).
interface mem_test_sequencer_if;
   // Command side
   logic                 cmd_valid;
   logic                 cmd_ready;
   logic [3:1][31:0]     cmd_param;
   logic                 abort;
   logic                 busy;
   // Result side
   logic                 res_valid;
   logic                 res_ready;
   logic                 res_timeout;
   logic [14:5][31:0]    res_data;
   // CSR Avalon-MM side
   logic                 csr_read;
   logic                 csr_write;
   logic [3:0]           csr_address;
   logic [31:0]          csr_writedata;
   logic [31:0]          csr_readdata;

   modport master (
      input  cmd_valid, cmd_param, abort, res_ready, csr_readdata,
      output cmd_ready, busy, res_valid, res_timeout, res_data,
             csr_read, csr_write, csr_address, csr_writedata
   );

   modport slave (
      output cmd_valid, cmd_param, abort, res_ready, csr_readdata,
      input  cmd_ready, busy, res_valid, res_timeout, res_data,
             csr_read, csr_write, csr_address, csr_writedata
   );
endinterface

// File: rtl/mem_test_sequencer.sv
// Purpose: runs one memory-checker test over the CSR Avalon-MM port: write params, start, poll, read results.
// Ports: clk_sys_i, rst_n_i (async active-low), bus (mem_test_sequencer_if.master).
// Latency: accept -> first write 1 cycle; finished sampled -> res_valid 11 edges; result held until res_ready.
module mem_test_sequencer #(
   parameter int unsigned POLL_GAP      = 16,     // idle cycles between status polls (>=1)
   parameter int unsigned TIMEOUT_POLLS = 65535   // polls before giving up; 0 = never
) (
   input  logic                 clk_sys_i,
   input  logic                 rst_n_i,
   mem_test_sequencer_if.master bus
);

   typedef enum logic [2:0] {
      S_IDLE, S_WR_PAR, S_WR_GO, S_WAIT, S_POLL, S_CHK, S_RD_RES, S_OUT
   } state_t;

   localparam logic [31:0] GAP_LAST = 32'(POLL_GAP - 1);

   state_t            state, state_nxt;
   logic [3:0]        idx, idx_nxt;          // param index in WR_PAR, CSR address in RD_RES
   logic [31:0]       wait_cnt, wait_nxt;
   logic [15:0]       poll_cnt, poll_nxt, poll_inc;
   logic [3:1][31:0]  param_q;
   logic              accept, set_timeout;
   logic              cap_vld;                // a result read was strobed last cycle
   logic [3:0]        cap_addr;

   // Avalon outputs are computed from the next state and registered.
   logic              read_d, write_d;
   logic [3:0]        addr_d;
   logic [31:0]       wdata_d;

   always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state    <= S_IDLE;
         idx      <= '0;
         wait_cnt <= '0;
         poll_cnt <= '0;
      end else begin
         state    <= state_nxt;
         idx      <= idx_nxt;
         wait_cnt <= wait_nxt;
         poll_cnt <= poll_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      idx_nxt     = idx;
      wait_nxt    = wait_cnt;
      poll_nxt    = poll_cnt;
      accept      = 1'b0;
      set_timeout = 1'b0;
      poll_inc    = (poll_cnt == 16'hFFFF) ? poll_cnt : poll_cnt + 16'd1;

      case (state)
         S_IDLE: begin
            if (bus.cmd_valid) begin
               accept    = 1'b1;
               state_nxt = S_WR_PAR;
               idx_nxt   = 4'd1;
               poll_nxt  = '0;
            end
         end
         S_WR_PAR: begin
            if (idx == 4'd3) state_nxt = S_WR_GO;
            else             idx_nxt   = idx + 4'd1;
         end
         S_WR_GO: begin
            state_nxt = S_WAIT;
            wait_nxt  = '0;
         end
         S_WAIT: begin
            if (wait_cnt == GAP_LAST) state_nxt = S_POLL;
            else                      wait_nxt  = wait_cnt + 32'd1;
         end
         S_POLL: state_nxt = S_CHK;
         S_CHK: begin
            // Read data of the addr-4 strobe is on the bus only in this cycle.
            if (bus.csr_readdata[0]) begin
               state_nxt = S_RD_RES;
               idx_nxt   = 4'd5;
            end else begin
               poll_nxt = poll_inc;
               if ((TIMEOUT_POLLS != 0) && ({16'd0, poll_inc} >= TIMEOUT_POLLS)) begin
                  state_nxt   = S_OUT;
                  set_timeout = 1'b1;
               end else if (POLL_GAP <= 1) begin
                  state_nxt = S_POLL;
               end else begin
                  // CHK itself is the first idle cycle of the gap.
                  state_nxt = S_WAIT;
                  wait_nxt  = 32'd1;
               end
            end
         end
         S_RD_RES: begin
            // idx 5..14 strobe reads; idx 15 only waits for the last capture.
            if (idx == 4'd15) state_nxt = S_OUT;
            else              idx_nxt   = idx + 4'd1;
         end
         S_OUT: begin
            if (bus.res_ready) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase

      if (bus.abort && (state != S_IDLE) && (state != S_OUT)) begin
         state_nxt   = S_IDLE;
         set_timeout = 1'b0;
      end

      read_d  = 1'b0;
      write_d = 1'b0;
      addr_d  = bus.csr_address;
      wdata_d = bus.csr_writedata;
      case (state_nxt)
         S_WR_PAR: begin
            write_d = 1'b1;
            addr_d  = idx_nxt;
            case (idx_nxt[1:0])
               2'd2:    wdata_d = param_q[2];
               2'd3:    wdata_d = param_q[3];
               default: wdata_d = bus.cmd_param[1];  // entered straight from accept
            endcase
         end
         S_WR_GO: begin
            write_d = 1'b1;
            addr_d  = 4'd0;
            wdata_d = 32'h1;
         end
         S_POLL: begin
            read_d = 1'b1;
            addr_d = 4'd4;
         end
         S_RD_RES: begin
            if (idx_nxt <= 4'd14) begin
               read_d = 1'b1;
               addr_d = idx_nxt;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         bus.csr_read      <= 1'b0;
         bus.csr_write     <= 1'b0;
         bus.csr_address   <= '0;
         bus.csr_writedata <= '0;
         bus.cmd_ready     <= 1'b1;
         bus.busy          <= 1'b0;
         bus.res_valid     <= 1'b0;
         bus.res_timeout   <= 1'b0;
         bus.res_data      <= '0;
         param_q           <= '0;
         cap_vld           <= 1'b0;
         cap_addr          <= '0;
      end else begin
         bus.csr_read      <= read_d;
         bus.csr_write     <= write_d;
         bus.csr_address   <= addr_d;
         bus.csr_writedata <= wdata_d;
         bus.cmd_ready     <= (state_nxt == S_IDLE);
         bus.busy          <= (state_nxt != S_IDLE);
         bus.res_valid     <= (state_nxt == S_OUT);
         cap_vld           <= bus.csr_read && (bus.csr_address != 4'd4);
         cap_addr          <= bus.csr_address;
         if (accept) begin
            param_q         <= bus.cmd_param;
            bus.res_data    <= '0;
            bus.res_timeout <= 1'b0;
         end else begin
            if (set_timeout) bus.res_timeout <= 1'b1;
            // An abort leaving RD_RES drops the in-flight capture.
            if ((state == S_RD_RES) && cap_vld && (state_nxt != S_IDLE)) begin
               for (int n = 5; n <= 14; n++) begin
                  if (cap_addr == 4'(n)) bus.res_data[n] <= bus.csr_readdata;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_test_sequencer.sv
module tb_mem_test_sequencer;

   typedef struct {
      logic [3:0]  a;
      logic [31:0] d;
   } wr_t;

   typedef struct {
      logic              to;
      logic [14:5][31:0] data;
   } res_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;

   mem_test_sequencer_if bus ();

   mem_test_sequencer #(.POLL_GAP(16), .TIMEOUT_POLLS(4)) dut (
      .clk_sys_i (clk),
      .rst_n_i   (rst_n),
      .bus       (bus.master)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // CSR block model
   logic [31:0] res_mem [0:15];
   int          finish_zeros = -1;   // polls returning 0 before finished; -1 = never
   int          polls_since_start = 0;

   always @(posedge clk) begin
      if (bus.csr_write && bus.csr_address == 4'd0 && bus.csr_writedata[0])
         polls_since_start <= 0;
      if (bus.csr_read) begin
         if (bus.csr_address == 4'd4) begin
            polls_since_start <= polls_since_start + 1;
            bus.csr_readdata  <= {31'd0, (finish_zeros >= 0) && (polls_since_start >= finish_zeros)};
         end else begin
            bus.csr_readdata <= res_mem[bus.csr_address];
         end
      end else begin
         bus.csr_readdata <= 32'hFFFF_FFFF;  // junk outside the valid cycle
      end
   end

   // Monitor: only appends observations
   wr_t  obs_wr[$];
   res_t obs_res[$];
   int   poll_cyc_q[$];
   int   rise_cyc_q[$];
   int   n_res_rd = 0;
   int   n_strobe = 0;
   logic res_valid_prev = 1'b0;

   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.csr_write) obs_wr.push_back('{a: bus.csr_address, d: bus.csr_writedata});
         if (bus.csr_read) begin
            if (bus.csr_address == 4'd4) poll_cyc_q.push_back(cyc);
            else                         n_res_rd = n_res_rd + 1;
         end
         if (bus.csr_read || bus.csr_write) n_strobe = n_strobe + 1;
         if (bus.res_valid && !res_valid_prev) rise_cyc_q.push_back(cyc);
         if (bus.res_valid && bus.res_ready)
            obs_res.push_back('{to: bus.res_timeout, data: bus.res_data});
         res_valid_prev = bus.res_valid;
      end else begin
         res_valid_prev = 1'b0;
      end
   end

   // Checking
   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk = n_chk + 1;
      if (obs === exp) n_pass = n_pass + 1;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   wr_t  exp_wr[$];
   res_t exp_res[$];
   int   obs_wr_idx  = 0;
   int   obs_res_idx = 0;

   task automatic drain();
      wr_t  ow, ew;
      res_t orr, er;
      while (obs_wr_idx < obs_wr.size()) begin
         ow = obs_wr[obs_wr_idx];
         obs_wr_idx++;
         if (exp_wr.size() == 0) check("wr_unexpected", 1, 0);
         else begin
            ew = exp_wr.pop_front();
            check("wr_addr", ow.a, ew.a);
            check("wr_data", ow.d, ew.d);
         end
      end
      check("wr_missing", exp_wr.size(), 0);
      exp_wr.delete();
      while (obs_res_idx < obs_res.size()) begin
         orr = obs_res[obs_res_idx];
         obs_res_idx++;
         if (exp_res.size() == 0) check("res_unexpected", 1, 0);
         else begin
            er = exp_res.pop_front();
            check("res_timeout", orr.to, er.to);
            for (int n = 5; n <= 14; n++)
               check($sformatf("res_data[%0d]", n), orr.data[n], er.data[n]);
         end
      end
      check("res_missing", exp_res.size(), 0);
      exp_res.delete();
   endtask

   task automatic fill_results(output logic [14:5][31:0] d);
      for (int n = 5; n <= 14; n++) begin
         res_mem[n] = $urandom;
         d[n] = res_mem[n];
      end
   endtask

   task automatic send_cmd(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
      bit acc;
      exp_wr.push_back('{a: 4'd1, d: a});
      exp_wr.push_back('{a: 4'd2, d: b});
      exp_wr.push_back('{a: 4'd3, d: c});
      exp_wr.push_back('{a: 4'd0, d: 32'h1});
      @(negedge clk);
      bus.cmd_valid    = 1'b1;
      bus.cmd_param[1] = a;
      bus.cmd_param[2] = b;
      bus.cmd_param[3] = c;
      acc = 1'b0;
      for (int i = 0; i < 50 && !acc; i++) begin
         if (bus.cmd_ready) acc = 1'b1;
         @(negedge clk);
      end
      bus.cmd_valid = 1'b0;
      check("cmd_accepted", acc, 1);
      // one cycle after the accepting edge the first write is on the bus
      check("first_wr_strobe", bus.csr_write, 1);
      check("first_wr_addr", bus.csr_address, 1);
   endtask

   task automatic wait_res_valid();
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 2000 && !seen; i++) begin
         @(negedge clk);
         if (bus.res_valid) seen = 1'b1;
      end
      check("res_valid_seen", seen, 1);
   endtask

   initial begin
      logic [14:5][31:0] d;
      logic [14:5][31:0] snap;
      int p0, r0, rr0, s0;
      bit stable, found;

      bus.cmd_valid    = 1'b0;
      bus.cmd_param    = '0;
      bus.abort        = 1'b0;
      bus.res_ready    = 1'b1;
      bus.csr_readdata = '0;

      // Reset values
      repeat (3) @(negedge clk);
      check("rst_cmd_ready", bus.cmd_ready, 1);
      check("rst_busy", bus.busy, 0);
      check("rst_res_valid", bus.res_valid, 0);
      check("rst_res_timeout", bus.res_timeout, 0);
      check("rst_csr_read", bus.csr_read, 0);
      check("rst_csr_write", bus.csr_write, 0);
      check("rst_csr_address", bus.csr_address, 0);
      check("rst_csr_writedata", bus.csr_writedata, 0);
      check("rst_res_data_nz", (bus.res_data != '0), 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Normal run: finished on the 4th poll
      finish_zeros = 3;
      fill_results(d);
      exp_res.push_back('{to: 1'b0, data: d});
      p0 = poll_cyc_q.size(); r0 = rise_cyc_q.size(); rr0 = n_res_rd;
      send_cmd(32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003);
      check("busy_running", bus.busy, 1);
      check("cmd_ready_running", bus.cmd_ready, 0);
      wait_res_valid();
      @(negedge clk);
      drain();
      check("t1_polls", poll_cyc_q.size() - p0, 4);
      for (int i = p0 + 1; i < poll_cyc_q.size(); i++)
         check("poll_gap", poll_cyc_q[i] - poll_cyc_q[i-1], 17);
      check("t1_res_reads", n_res_rd - rr0, 10);
      // poll strobe, CHK one cycle later, then 11 edges to res_valid
      if (rise_cyc_q.size() > r0 && poll_cyc_q.size() > p0)
         check("chk_to_valid", rise_cyc_q[r0] - poll_cyc_q[poll_cyc_q.size()-1], 13);
      else
         check("chk_to_valid_seen", 0, 1);

      // Timeout run
      finish_zeros = -1;
      exp_res.push_back('{to: 1'b1, data: '0});
      p0 = poll_cyc_q.size(); rr0 = n_res_rd;
      send_cmd(32'h1, 32'h2, 32'h3);
      wait_res_valid();
      check("t3_timeout_flag", bus.res_timeout, 1);
      @(negedge clk);
      drain();
      check("t3_polls", poll_cyc_q.size() - p0, 4);
      check("t3_res_reads", n_res_rd - rr0, 0);

      // Result held under backpressure
      finish_zeros = 0;
      bus.res_ready = 1'b0;
      fill_results(d);
      exp_res.push_back('{to: 1'b0, data: d});
      send_cmd(32'h1111_0000, 32'h2222_0000, 32'h3333_0000);
      wait_res_valid();
      snap = bus.res_data;
      stable = 1'b1;
      repeat (20) begin
         @(negedge clk);
         if (!bus.res_valid || bus.res_data != snap || bus.cmd_ready || !bus.busy) stable = 1'b0;
      end
      check("t4_held_stable", stable, 1);
      bus.res_ready = 1'b1;
      @(negedge clk);
      check("t4_cmd_ready_after", bus.cmd_ready, 1);
      check("t4_res_valid_after", bus.res_valid, 0);
      check("t4_busy_after", bus.busy, 0);
      drain();

      // Abort during result reads
      finish_zeros = 0;
      fill_results(d);
      rr0 = n_res_rd; r0 = rise_cyc_q.size();
      send_cmd(32'h5, 32'h6, 32'h7);
      found = 1'b0;
      for (int i = 0; i < 500 && !found; i++) begin
         @(negedge clk);
         if (bus.csr_read && bus.csr_address == 4'd8) found = 1'b1;
      end
      check("t5_addr8_seen", found, 1);
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      check("t5_busy", bus.busy, 0);
      check("t5_cmd_ready", bus.cmd_ready, 1);
      check("t5_csr_read", bus.csr_read, 0);
      s0 = n_strobe;
      repeat (30) @(negedge clk);
      check("t5_no_strobes", n_strobe - s0, 0);
      check("t5_res_reads", n_res_rd - rr0, 4);
      check("t5_no_res_valid", rise_cyc_q.size() - r0, 0);
      drain();
      fill_results(d);
      exp_res.push_back('{to: 1'b0, data: d});
      send_cmd(32'h9, 32'hA, 32'hB);
      wait_res_valid();
      @(negedge clk);
      drain();

      // Reset in the middle of WAIT
      finish_zeros = -1;
      send_cmd(32'hD, 32'hE, 32'hF);
      repeat (8) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("t6_busy", bus.busy, 0);
      check("t6_cmd_ready", bus.cmd_ready, 1);
      check("t6_csr_write", bus.csr_write, 0);
      check("t6_csr_read", bus.csr_read, 0);
      check("t6_csr_address", bus.csr_address, 0);
      check("t6_csr_writedata", bus.csr_writedata, 0);
      check("t6_res_valid", bus.res_valid, 0);
      @(negedge clk);
      rst_n = 1'b1;
      s0 = n_strobe;
      repeat (30) @(negedge clk);
      check("t6_no_strobes", n_strobe - s0, 0);
      check("t6_cmd_ready_idle", bus.cmd_ready, 1);
      drain();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
